// File: rtl/obstacle_spawner.sv
// obstacle_spawner
// Turns the serial LFSR bit stream into obstacle spawn descriptors. It
// collects 8 random bits, splits them into lane, kind and gap extension,
// waits the gap in frame ticks, and then offers the descriptor downstream
// over a valid/ready handshake.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   enable       game running (level)
//   rnd_bit      serial random bit, sampled on each edge in GATHER
//   frame_tick   one-cycle pulse per video frame
//   spawn_ready  downstream accepts the descriptor
//   spawn_valid  descriptor offered (registered)
//   spawn_lane   lane index 0..NUM_LANES-1 (registered)
//   spawn_kind   00 missile, 01 h-zapper, 10 v-zapper, 11 coins (registered)
//   spawn_count  completed transfers, wraps at 256 (registered)
//   busy         spawner is not idle (registered)
module obstacle_spawner #(
    parameter int NUM_LANES = 6,
    parameter int GAP_MIN   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       rnd_bit,
    input  logic       frame_tick,
    input  logic       spawn_ready,
    output logic       spawn_valid,
    output logic [2:0] spawn_lane,
    output logic [1:0] spawn_kind,
    output logic [7:0] spawn_count,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATHER = 2'd1,
        WAIT   = 2'd2,
        OFFER  = 2'd3
    } state_t;

    localparam logic [3:0] NL  = 4'(NUM_LANES);
    localparam logic [7:0] GAP = 8'(GAP_MIN);

    state_t     state, state_next;
    logic [7:0] shreg, shreg_next;
    logic [2:0] bit_cnt, bit_cnt_next;
    logic [7:0] gap_cnt, gap_next;
    logic       prev_valid, prev_valid_next;
    logic [2:0] prev_lane, prev_lane_next;
    logic [2:0] lane_next;
    logic [1:0] kind_next;
    logic [7:0] count_next;
    logic [7:0] sh_shift;

    // Fold the raw 3-bit lane into range, then step past the previous lane
    // so two consecutive obstacles never share a lane.
    function automatic logic [2:0] map_lane(input logic [2:0] raw,
                                            input logic       pv,
                                            input logic [2:0] pl);
        logic [3:0] l;
        l = {1'b0, raw};
        if (l >= NL) begin
            l = l - NL;
        end else begin
            l = l;
        end
        if (pv && (l[2:0] == pl)) begin
            if (l == (NL - 4'd1)) begin
                l = 4'd0;
            end else begin
                l = l + 4'd1;
            end
        end else begin
            l = l;
        end
        return l[2:0];
    endfunction

    // Next-state and next-register logic for the spawn sequencer.
    always_comb begin
        state_next      = state;
        shreg_next      = shreg;
        bit_cnt_next    = bit_cnt;
        gap_next        = gap_cnt;
        prev_valid_next = prev_valid;
        prev_lane_next  = prev_lane;
        lane_next       = spawn_lane;
        kind_next       = spawn_kind;
        count_next      = spawn_count;
        sh_shift        = {shreg[6:0], rnd_bit};

        case (state)
            IDLE: begin
                if (enable) begin
                    state_next   = GATHER;
                    bit_cnt_next = 3'd0;
                end else begin
                    state_next = IDLE;
                end
            end
            GATHER: begin
                if (!enable) begin
                    state_next   = IDLE;
                    bit_cnt_next = 3'd0;
                end else begin
                    shreg_next = sh_shift;
                    if (bit_cnt == 3'd7) begin
                        // 8th sample: descriptor complete, fields taken from
                        // the freshly shifted value.
                        state_next   = WAIT;
                        bit_cnt_next = 3'd0;
                        lane_next    = map_lane(sh_shift[7:5], prev_valid, prev_lane);
                        kind_next    = sh_shift[4:3];
                        gap_next     = GAP + {5'd0, sh_shift[2:0]};
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
            end
            WAIT: begin
                if (!enable) begin
                    state_next = IDLE;
                end else if (gap_cnt == 8'd0) begin
                    state_next = OFFER;
                end else if (frame_tick) begin
                    gap_next = gap_cnt - 8'd1;
                    if (gap_cnt == 8'd1) begin
                        state_next = OFFER;
                    end else begin
                        state_next = WAIT;
                    end
                end else begin
                    state_next = WAIT;
                end
            end
            OFFER: begin
                // enable is deliberately ignored until the transfer completes.
                if (spawn_valid && spawn_ready) begin
                    count_next      = spawn_count + 8'd1;
                    prev_valid_next = 1'b1;
                    prev_lane_next  = spawn_lane;
                    bit_cnt_next    = 3'd0;
                    state_next      = enable ? GATHER : IDLE;
                end else begin
                    state_next = OFFER;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; outputs are registered from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= 8'd0;
            bit_cnt     <= 3'd0;
            gap_cnt     <= 8'd0;
            prev_valid  <= 1'b0;
            prev_lane   <= 3'd0;
            spawn_valid <= 1'b0;
            spawn_lane  <= 3'd0;
            spawn_kind  <= 2'd0;
            spawn_count <= 8'd0;
            busy        <= 1'b0;
        end else begin
            state       <= state_next;
            shreg       <= shreg_next;
            bit_cnt     <= bit_cnt_next;
            gap_cnt     <= gap_next;
            prev_valid  <= prev_valid_next;
            prev_lane   <= prev_lane_next;
            spawn_valid <= (state_next == OFFER);
            spawn_lane  <= lane_next;
            spawn_kind  <= kind_next;
            spawn_count <= count_next;
            busy        <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Self-checking bench for obstacle_spawner. A default instance (6 lanes,
// GAP_MIN=8) runs the main scenarios; a second instance with GAP_MIN=0
// checks the minimum enable-to-valid latency.
module tb_obstacle_spawner;

    logic       clk;
    logic       rst;
    logic       enable, rnd_bit, frame_tick, spawn_ready;
    logic       spawn_valid, busy;
    logic [2:0] spawn_lane;
    logic [1:0] spawn_kind;
    logic [7:0] spawn_count;

    logic       z_enable, z_rnd, z_tick, z_ready;
    logic       z_valid, z_busy;
    logic [2:0] z_lane;
    logic [1:0] z_kind;
    logic [7:0] z_count;

    int checks   = 0;
    int failures = 0;

    logic [4:0] sb_q[$];
    logic       m_prev_valid;
    logic [2:0] m_prev_lane;
    int         cur_gap;

    obstacle_spawner #(.NUM_LANES(6), .GAP_MIN(8)) dut (
        .clk(clk), .rst(rst), .enable(enable), .rnd_bit(rnd_bit),
        .frame_tick(frame_tick), .spawn_ready(spawn_ready),
        .spawn_valid(spawn_valid), .spawn_lane(spawn_lane),
        .spawn_kind(spawn_kind), .spawn_count(spawn_count), .busy(busy)
    );

    obstacle_spawner #(.NUM_LANES(6), .GAP_MIN(0)) dut_z (
        .clk(clk), .rst(rst), .enable(z_enable), .rnd_bit(z_rnd),
        .frame_tick(z_tick), .spawn_ready(z_ready),
        .spawn_valid(z_valid), .spawn_lane(z_lane),
        .spawn_kind(z_kind), .spawn_count(z_count), .busy(z_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_lane(input logic [2:0] raw, input logic pv,
                                            input logic [2:0] pl);
        int l;
        l = int'(raw);
        if (l >= 6) l = l - 6;
        if (pv && (l == int'(pl))) l = (l == 5) ? 0 : l + 1;
        return 3'(l);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feed one byte MSB first (DUT already in GATHER), push expectation.
    task automatic gather(input logic [7:0] b);
        logic [2:0] el;
        for (int i = 7; i >= 0; i--) begin
            rnd_bit = b[i];
            step();
        end
        el = exp_lane(b[7:5], m_prev_valid, m_prev_lane);
        sb_q.push_back({el, b[4:3]});
        cur_gap = 8 + int'(b[2:0]);
        check_eq("gather_lane", 32'(spawn_lane), 32'(el));
        check_eq("gather_kind", 32'(spawn_kind), 32'(b[4:3]));
        check_eq("gather_valid", 32'(spawn_valid), 32'd0);
        check_eq("gather_busy", 32'(busy), 32'd1);
    endtask

    // Deliver n frame tick pulses; valid must rise right after the n-th.
    task automatic wait_ticks(input int n);
        for (int k = 1; k <= n; k++) begin
            check_eq("wait_no_valid", 32'(spawn_valid), 32'd0);
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            if (k < n) step();
        end
        check_eq("offer_valid", 32'(spawn_valid), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, 32'(spawn_valid), 32'd0);
        check_eq({tag, "_lane"},  32'(spawn_lane),  32'd0);
        check_eq({tag, "_kind"},  32'(spawn_kind),  32'd0);
        check_eq({tag, "_count"}, 32'(spawn_count), 32'd0);
        check_eq({tag, "_busy"},  32'(busy),        32'd0);
    endtask

    // Scoreboard: a transfer happens at the next posedge; compare it now.
    always @(negedge clk) begin
        if (!rst && spawn_valid && spawn_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected", 32'd1, 32'd0);
            end else begin
                logic [4:0] e;
                e = sb_q.pop_front();
                check_eq("sb_lane", 32'(spawn_lane), 32'(e[4:2]));
                check_eq("sb_kind", 32'(spawn_kind), 32'(e[1:0]));
                m_prev_valid = 1'b1;
                m_prev_lane  = e[4:2];
            end
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b0; rnd_bit = 1'b0; frame_tick = 1'b0; spawn_ready = 1'b0;
        z_enable = 1'b0; z_rnd = 1'b0; z_tick = 1'b0; z_ready = 1'b0;
        m_prev_valid = 1'b0; m_prev_lane = 3'd0; cur_gap = 0;
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        // Zero gap: valid exactly 10 edges after enable is first sampled.
        z_enable = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (e == 9)  check_eq("zero_gap_e9",  32'(z_valid), 32'd0);
            if (e == 10) check_eq("zero_gap_e10", 32'(z_valid), 32'd1);
        end
        check_eq("zero_gap_lane", 32'(z_lane), 32'd0);

        // Basic spawn: 0xAD -> lane 5, kind 01, gap 13.
        enable = 1'b1; spawn_ready = 1'b1;
        step();
        check_eq("basic_busy", 32'(busy), 32'd1);
        gather(8'hAD);
        check_eq("basic_gap", 32'(cur_gap), 32'd13);
        wait_ticks(cur_gap);
        step();
        check_eq("basic_valid_drop", 32'(spawn_valid), 32'd0);
        check_eq("basic_count", 32'(spawn_count), 32'd1);
        check_eq("basic_regather", 32'(busy), 32'd1);

        // Repeat-avoid wrap: raw 5 after lane 5 -> lane 0.
        gather(8'hA0);
        check_eq("wrap_lane", 32'(spawn_lane), 32'd0);
        wait_ticks(cur_gap);
        step();
        check_eq("wrap_count", 32'(spawn_count), 32'd2);

        // Fold: raw 7 -> lane 1.
        gather(8'hE8);
        check_eq("fold_lane", 32'(spawn_lane), 32'd1);
        wait_ticks(cur_gap);
        step();
        check_eq("fold_count", 32'(spawn_count), 32'd3);

        // Backpressure: 20 cycles of ready=0 with enable/rnd_bit toggling.
        spawn_ready = 1'b0;
        gather(8'h50);
        wait_ticks(cur_gap);
        for (int k = 0; k < 20; k++) begin
            enable  = k[0];
            rnd_bit = ~rnd_bit;
            step();
            check_eq("bp_valid", 32'(spawn_valid), 32'd1);
            check_eq("bp_lane",  32'(spawn_lane),  32'd2);
            check_eq("bp_kind",  32'(spawn_kind),  32'd2);
            check_eq("bp_count", 32'(spawn_count), 32'd3);
        end
        enable = 1'b1; spawn_ready = 1'b1;
        step();
        check_eq("bp_done_count", 32'(spawn_count), 32'd4);
        check_eq("bp_done_valid", 32'(spawn_valid), 32'd0);

        // Abort after 4 samples, then a fresh full gather.
        for (int k = 0; k < 4; k++) begin
            rnd_bit = 1'b1;
            step();
        end
        enable = 1'b0;
        step();
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_count", 32'(spawn_count), 32'd4);
        enable = 1'b1;
        step();
        gather(8'h38);
        wait_ticks(cur_gap);
        step();
        check_eq("abort_regather_count", 32'(spawn_count), 32'd5);

        // Reset during WAIT.
        gather(8'h20);
        rst = 1'b1; enable = 1'b0;
        step();
        check_reset_outputs("rst_wait");
        sb_q.delete();
        m_prev_valid = 1'b0;
        rst = 1'b0;

        // Reset during OFFER; repeat-avoid must be off (raw 1 -> lane 1).
        enable = 1'b1; spawn_ready = 1'b0;
        step();
        gather(8'h20);
        check_eq("noprev_lane", 32'(spawn_lane), 32'd1);
        wait_ticks(cur_gap);
        rst = 1'b1; enable = 1'b0;
        step();
        check_reset_outputs("rst_offer");
        sb_q.delete();
        m_prev_valid = 1'b0;
        rst = 1'b0;

        // Recovery: first transfer after reset counts from zero.
        enable = 1'b1; spawn_ready = 1'b1;
        step();
        gather(8'h20);
        check_eq("post_rst_lane", 32'(spawn_lane), 32'd1);
        wait_ticks(cur_gap);
        step();
        check_eq("post_rst_count", 32'(spawn_count), 32'd1);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/obstacle_spawner.md
Name: obstacle_spawner

Overview:
- Consumes the serial pseudo-random bit stream from the game's LFSR number generator.
- Assembles 8 random bits into a spawn descriptor: lane, obstacle kind and gap length.
- Waits the gap in frame ticks, then offers the obstacle to the sprite/obstacle manager over a valid/ready handshake.
- Sits between the LFSR (upstream) and the obstacle sprite logic (downstream).

Parameters:
- NUM_LANES, 6: number of vertical lanes; legal range 5..8.
- GAP_MIN, 8: minimum frame ticks between spawns; legal range 0..247.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- enable, input, 1: game running; level-sensitive.
- rnd_bit, input, 1: random bit from the LFSR output, sampled on every clk edge while in GATHER.
- frame_tick, input, 1: one-cycle pulse per video frame.
- spawn_ready, input, 1: downstream accepts the descriptor.
- spawn_valid, output, 1: descriptor offered.
- spawn_lane, output, 3: lane index, always 0..NUM_LANES-1.
- spawn_kind, output, 2: 00 missile, 01 horizontal zapper, 10 vertical zapper, 11 coin group.
- spawn_count, output, 8: number of completed transfers; wraps 255 -> 0.
- busy, output, 1: state != IDLE.

Behaviour:
- States: IDLE, GATHER, WAIT, OFFER. All transitions occur on the clk rising edge.
- Reset (rst=1 at an edge, from any state):
  - state=IDLE.
  - spawn_valid=0, spawn_lane=0, spawn_kind=0, spawn_count=0, busy=0.
  - Shift register=0, bit counter=0, gap counter=0.
  - prev_valid=0, prev_lane=0.
  - Reset overrides every other input, including an in-progress handshake; an OFFER is dropped without counting.
- IDLE -> GATHER when enable=1. The bit counter is cleared.
- GATHER:
  - On each edge: shreg <= {shreg[6:0], rnd_bit}; counter increments.
  - After exactly 8 samples (8 edges in GATHER), go to WAIT. The first sampled bit ends up in shreg[7].
  - Field split: raw_lane=shreg[7:5], kind=shreg[4:3], extra=shreg[2:0].
- Lane mapping, computed when leaving GATHER:
  - l = raw_lane if raw_lane < NUM_LANES, else raw_lane - NUM_LANES.
  - If prev_valid and l == prev_lane: l = l+1, wrapping NUM_LANES-1 -> 0.
  - spawn_lane and spawn_kind are registered on this edge and stay stable until the next GATHER exit.
- WAIT:
  - Gap counter is loaded with GAP_MIN+extra (8-bit) on entry.
  - If the counter is 0, go to OFFER on the next edge; no frame_tick is needed.
  - Otherwise decrement on each edge with frame_tick=1. The edge that decrements 1 -> 0 moves to OFFER.
  - A frame_tick coincident with GATHER -> WAIT entry is ignored.
- OFFER:
  - spawn_valid=1. Lane and kind are held stable.
  - On an edge with spawn_valid & spawn_ready:
    - spawn_valid=0.
    - prev_lane <= spawn_lane, prev_valid <= 1.
    - spawn_count += 1.
    - Next state is GATHER if enable=1, else IDLE.
  - No bits are sampled in OFFER.
- enable deasserted:
  - In GATHER or WAIT: go to IDLE on the next edge. The partial descriptor is discarded and spawn_count is unchanged.
  - In OFFER: ignored until the handshake completes (valid is never withdrawn).
- spawn_valid is asserted only in OFFER and rises one edge after the WAIT exit condition.
- Minimum latency enable -> spawn_valid: 1 edge (IDLE->GATHER) + 8 (GATHER) + 1 (WAIT with a zero gap) = 10 edges.
- prev_valid is cleared only by rst, not by returning to IDLE.

Test Plan:
- Basic spawn (NUM_LANES=6, GAP_MIN=8):
  - Stimulus: after rst, enable=1, rnd_bit sequence 1,0,1,0,1,1,0,1.
  - Required: shreg=8'hAD, lane=5, kind=01, gap=13. spawn_valid rises one edge after the 13th frame_tick.
  - With spawn_ready=1: one-cycle valid, spawn_count=1, state returns to GATHER.
- Lane fold and repeat-avoid:
  - Following the basic spawn (prev_lane=5), bits 1,1,1,… give raw_lane=7 -> lane 1.
  - Bits 1,0,1,… give raw_lane=5, equal to prev_lane -> lane 0 (wrap).
- Backpressure: hold spawn_ready=0 for 20 cycles in OFFER, toggling enable and rnd_bit. Required: valid stays 1, lane/kind unchanged, count unchanged; the transfer completes on the first ready=1 edge.
- Zero gap: GAP_MIN=0, extra bits 000, frame_tick held 0. Required: spawn_valid=1 exactly 10 edges after enable is first sampled high.
- Abort: drop enable after 4 GATHER samples -> busy=0 next edge. Re-enable -> a fresh 8-bit gather from an empty counter; spawn_count unchanged.
- Reset mid-operation: assert rst during OFFER and during WAIT. Required: all outputs 0 and IDLE on the next edge; after re-enable, lane repeat-avoid is inactive (prev_valid=0).
